config_chain_loader: RTL and testbench
======================================

# config_chain_loader

Controller that programs the configuration chain (ccff) feeding the fabric's routing and interconnect muxes. It accepts a bitstream as words over a valid/ready handshake, serializes each word LSB-first onto `ccff_head` with a matching shift enable, and counts exactly `CHAIN_LEN` bits. It sits between the bitstream source (host/JTAG bridge) and the `ccff_head`/`ccff_tail` ends of the fabric configuration chain.

## Interface
Parameters:
- `CHAIN_LEN`, 64: total configuration bits in the chain; must be ≥1.
- `WORD_W`, 8: bitstream word width; must be ≥1.

Ports:
- `prog_clk`  in  1  programming clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a full chain load; sampled only in IDLE.
- `word_data`  in  WORD_W  bitstream word; bit 0 is shifted first.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  loader accepts a word this cycle.
- `ccff_head`  out  1  serial data into the chain.
- `shift_en`  out  1  chain shifts on the `prog_clk` edge where this is high.
- `ccff_tail`  in  1  chain output (used only with readback).
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  sticky; set when the load (and readback, if built) completes, cleared by the next accepted `start`.
- `error`  out  1  sticky readback mismatch; held at 0 without readback.

## Operation
- States: IDLE, LOAD, SHIFT, VERIFY (readback only), DONE.
- IDLE/DONE + `start` → LOAD. Clear `bit_cnt`, `done`, `error`; with readback, set the CRC to its init value.
- LOAD: `word_ready`=1. On `word_valid && word_ready`, capture the word into `sreg`, clear `sub_cnt`, and go to SHIFT. `word_valid` low causes a wait with no side effects.
- SHIFT: each cycle, drive `ccff_head`=`sreg[0]` and `shift_en`=1; shift `sreg` right; increment `bit_cnt` and `sub_cnt`. Exit SHIFT on the cycle that emits bit `CHAIN_LEN-1` or bit `WORD_W-1` of the current word:
  - `bit_cnt` reaches `CHAIN_LEN`: go to VERIFY with readback, otherwise DONE.
  - otherwise: go to LOAD.
- Partial last word: when `CHAIN_LEN % WORD_W != 0`, the unused upper bits of the final word are discarded, never shifted.
- Words accepted per load: exactly ceil(`CHAIN_LEN`/`WORD_W`).
- `bit_cnt` width is clog2(`CHAIN_LEN`+1) and never wraps. `sub_cnt` width is clog2(`WORD_W`+1).
- `start` outside IDLE/DONE is ignored.

## Timing
- Reset values: `word_ready`=0, `ccff_head`=0, `shift_en`=0, `busy`=0, `done`=0, `error`=0; state=IDLE.
- All outputs are registered. `ccff_head` and `shift_en` change together.
- `start` at cycle t makes `word_ready`=1 at t+1.
- A handshake at cycle h puts the first bit on `ccff_head` with `shift_en`=1 at h+1.
- Each word takes 1 load cycle plus min(`WORD_W`, remaining) shift cycles, given an immediately valid source.
- `done` rises the cycle after the final shift (or the final VERIFY cycle). `busy` falls in that same cycle.
- `reset` at any point returns to IDLE on the next edge and `shift_en` drops immediately. The chain contents are then undefined, and a new `start` is required.

## Configuration
- Macro: `CFG_READBACK_EN`.
- Defined:
  - During SHIFT, a serial CRC-16 (poly 0x1021, init 0xFFFF) is computed over the bits driven on `ccff_head`.
  - VERIFY then runs `CHAIN_LEN` cycles with `shift_en`=1 and `ccff_head`=`ccff_tail`. This recirculates the chain, leaves its contents intact, and emits the bits in load order.
  - A second CRC is computed over `ccff_tail` during VERIFY. On exit, `error` is set if the two CRCs differ.
- Undefined: no VERIFY state and no CRC logic; SHIFT goes straight to DONE; `error` is tied to 0.

## Structure
- Shared package `cfg_loader_pkg` holds:
  - the state enum;
  - `CRC16_POLY` = 16'h1021 and `CRC16_INIT` = 16'hFFFF;
  - the helper function that computes the word count.
- Sub-module `cfg_crc16`: serial one-bit-per-cycle CRC with `clear`, `en` and `din` inputs. It is instantiated twice under `CFG_READBACK_EN`.

## Test plan
- `CHAIN_LEN`=16, `WORD_W`=8, words 0xA5 then 0x3C → `ccff_head` = 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0 over 16 `shift_en` cycles; exactly 2 handshakes; `done`=1 one cycle after the last bit.
- `CHAIN_LEN`=12, `WORD_W`=8, words 0x00 then 0xFF → 12 `shift_en` cycles; the last 4 bits are 1; no third `word_ready`.
- Backpressure: `word_valid` held low for 5 cycles between words → `shift_en`=0 throughout the gap; the bit sequence is identical to the no-gap case.
- Reset after the 3rd shift bit → next cycle all outputs 0 and state IDLE. A new `start` with 0xA5/0x3C then reproduces scenario 1.
- `start` pulsed during SHIFT → ignored; the bit count and `done` timing are unchanged.
- `CFG_READBACK_EN`, bench models the chain as a 16-bit shift loop:
  - clean chain → VERIFY lasts 16 cycles, then `done`=1, `error`=0, and the model contents equal 0x3CA5;
  - one bit of the model forced flipped before VERIFY → `done`=1, `error`=1.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// rtl/cfg_loader_pkg.sv - shared types, CRC constants and word-count helper for the config chain loader
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_VERIFY,
        ST_DONE
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Number of bitstream words needed to fill a chain of chain_len bits.
    function automatic int unsigned words_for(input int unsigned chain_len,
                                              input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/cfg_crc16.sv
// rtl/cfg_crc16.sv - serial one-bit-per-cycle CRC-16 (poly 0x1021, init 0xFFFF)
module cfg_crc16
    import cfg_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic        din_i,
    output logic [15:0] crc_o,
    output logic [15:0] crc_next_o
);

    logic [15:0] crc_q;
    logic        fb;

    // crc_next_o is the value after absorbing din_i, so a caller can compare on the final bit.
    always_comb begin
        fb         = crc_q[15] ^ din_i;
        crc_next_o = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            crc_q <= CRC16_INIT;
        end else if (en_i) begin
            crc_q <= crc_next_o;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - serializes bitstream words LSB-first into the fabric config chain
// Optional readback verification (recirculate + CRC compare) built with CFG_READBACK_EN.
module config_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam int SCW = $clog2(WORD_W + 1);
    localparam logic [BCW-1:0] CHAIN_LAST = BCW'(CHAIN_LEN - 1);
    localparam logic [SCW-1:0] WORD_LAST  = SCW'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SCW-1:0]    sub_cnt_q, sub_cnt_d;
    logic              head_q, head_d;
    logic              shift_q, shift_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_bit;

`ifdef CFG_READBACK_EN
    logic              error_q, error_d;
    logic              crc_clear, crc_tx_en, crc_rx_en;
    logic [15:0]       crc_tx, crc_tx_next_unused;
    logic [15:0]       crc_rx_unused, crc_rx_next;
`endif

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        sub_cnt_d = sub_cnt_q;
        head_d    = 1'b0;
        shift_d   = 1'b0;
        done_d    = done_q;
        last_bit  = (bit_cnt_q == CHAIN_LAST) || (sub_cnt_q == WORD_LAST);
`ifdef CFG_READBACK_EN
        error_d   = error_q;
        crc_clear = 1'b0;
        crc_tx_en = 1'b0;
        crc_rx_en = 1'b0;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                    done_d    = 1'b0;
`ifdef CFG_READBACK_EN
                    error_d   = 1'b0;
                    crc_clear = 1'b1;
`endif
                end
            end
            ST_LOAD: begin
                if (word_valid && ready_q) begin
                    head_d    = word_data[0];
                    sreg_d    = word_data >> 1;
                    shift_d   = 1'b1;
                    sub_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // head_q is the bit on ccff_head this cycle; prepare the next one unless this is the last.
`ifdef CFG_READBACK_EN
                crc_tx_en = 1'b1;
`endif
                bit_cnt_d = bit_cnt_q + BCW'(1);
                sub_cnt_d = sub_cnt_q + SCW'(1);
                if (last_bit) begin
                    if (bit_cnt_q == CHAIN_LAST) begin
`ifdef CFG_READBACK_EN
                        state_d   = ST_VERIFY;
                        bit_cnt_d = '0;
                        shift_d   = 1'b1;
`else
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
`endif
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    head_d  = sreg_q[0];
                    sreg_d  = sreg_q >> 1;
                    shift_d = 1'b1;
                end
            end
`ifdef CFG_READBACK_EN
            ST_VERIFY: begin
                crc_rx_en = 1'b1;
                bit_cnt_d = bit_cnt_q + BCW'(1);
                if (bit_cnt_q == CHAIN_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    error_d = (crc_tx != crc_rx_next);
                end else begin
                    shift_d = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge prog_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            sub_cnt_q <= '0;
            head_q    <= 1'b0;
            shift_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            sub_cnt_q <= sub_cnt_d;
            head_q    <= head_d;
            shift_q   <= shift_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef CFG_READBACK_EN
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    cfg_crc16 u_crc_tx (
        .clk_i      (prog_clk),
        .reset_i    (reset),
        .clear_i    (crc_clear),
        .en_i       (crc_tx_en),
        .din_i      (head_q),
        .crc_o      (crc_tx),
        .crc_next_o (crc_tx_next_unused)
    );

    cfg_crc16 u_crc_rx (
        .clk_i      (prog_clk),
        .reset_i    (reset),
        .clear_i    (crc_clear),
        .en_i       (crc_rx_en),
        .din_i      (ccff_tail),
        .crc_o      (crc_rx_unused),
        .crc_next_o (crc_rx_next)
    );

    // Recirculation needs the tail on the head at the same edge; a registered copy would rotate the chain by one.
    assign ccff_head = (state_q == ST_VERIFY) ? ccff_tail : head_q;
    assign error     = error_q;
`else
    logic tail_unused;
    assign tail_unused = ccff_tail;
    assign ccff_head   = head_q;
    assign error       = 1'b0;
`endif

    assign shift_en   = shift_q;
    assign word_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - scoreboard bench for config_chain_loader (16- and 12-bit chains)
module tb_config_chain_loader;
    import cfg_loader_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start_a, start_b, word_valid;
    logic [7:0] word_data;
    logic       ready_a, head_a, sh_a, busy_a, done_a, err_a, tail_a;
    logic       ready_b, head_b, sh_b, busy_b, done_b, err_b, tail_b;
    logic [15:0] chain_a = 16'h0;
    logic [11:0] chain_b = 12'h0;
    bit          inject = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_a = 0, cnt_b = 0, hs_a = 0, hs_b = 0;
    int base_cnt, base_hs;
    bit exp_q[$];

    always #5 clk = ~clk;

    config_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
        .prog_clk(clk), .reset(reset), .start(start_a), .word_data(word_data),
        .word_valid(word_valid), .word_ready(ready_a), .ccff_head(head_a),
        .shift_en(sh_a), .ccff_tail(tail_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    config_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
        .prog_clk(clk), .reset(reset), .start(start_b), .word_data(word_data),
        .word_valid(word_valid), .word_ready(ready_b), .ccff_head(head_b),
        .shift_en(sh_b), .ccff_tail(tail_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    // Chain models: first bit shifted in ends at index 0, which is the tail.
    assign tail_a = chain_a[0];
    assign tail_b = chain_b[0];

    always @(posedge clk) begin
        if (sh_a) begin
            if (inject && (cnt_a - base_cnt) == 16)
                chain_a <= {head_a, chain_a[15:1]} ^ 16'h0100;
            else
                chain_a <= {head_a, chain_a[15:1]};
        end
        if (sh_b) chain_b <= {head_b, chain_b[11:1]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_cmp(input string tag, input logic got);
        if (exp_q.size() == 0) chk({tag, "_underflow"}, 32'd1, 32'd0);
        else chk(tag, {31'd0, got}, {31'd0, exp_q.pop_front()});
    endtask

    always @(negedge clk) begin
        if (sh_a) begin
            if ((cnt_a - base_cnt) < 16) pop_cmp("head_a", head_a);
            cnt_a++;
        end
        if (sh_b) begin
            pop_cmp("head_b", head_b);
            cnt_b++;
        end
        if (word_valid && ready_a) hs_a++;
        if (word_valid && ready_b) hs_b++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input bit sel_b);
        return sel_b ? ready_b : ready_a;
    endfunction

    task automatic send_word(input bit sel_b, input logic [7:0] w, input int nb,
                             input int gap, input bit poke);
        int n = 0;
        word_data  = w;
        word_valid = (gap == 0);
        while (!rdy(sel_b) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        for (int g = 0; g < gap; g++) begin
            chk("gap_shift_en", {31'd0, sel_b ? sh_b : sh_a}, 32'd0);
            step();
        end
        word_valid = 1'b1;
        for (int i = 0; i < nb; i++) exp_q.push_back(w[i]);
        step();
        word_valid = 1'b0;
        word_data  = 8'h00;
        if (poke) begin
            step();
            if (sel_b) start_b = 1'b1; else start_a = 1'b1;
            step();
            start_a = 1'b0;
            start_b = 1'b0;
        end
    endtask

    task automatic run_load(input bit sel_b, input logic [7:0] w0, input logic [7:0] w1,
                            input int gap, input bit poke, input bit exp_err);
        int len = sel_b ? 12 : 16;
        int nw  = int'(words_for(len, 8));
        int nb, n, vlen;
        vlen = 0;
`ifdef CFG_READBACK_EN
        vlen = len;
`endif
        base_cnt = sel_b ? cnt_b : cnt_a;
        base_hs  = sel_b ? hs_b : hs_a;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        chk("ready_after_start", {31'd0, rdy(sel_b)}, 32'd1);
        chk("done_cleared", {31'd0, sel_b ? done_b : done_a}, 32'd0);
        chk("busy_in_load", {31'd0, sel_b ? busy_b : busy_a}, 32'd1);
        nb = 0;
        for (int k = 0; k < nw; k++) begin
            nb = (len - 8 * k < 8) ? len - 8 * k : 8;
            send_word(sel_b, (k == 0) ? w0 : w1, nb, (k > 0) ? gap : 0, poke && k == 0);
        end
        n = 0;
        while (!(sel_b ? done_b : done_a) && n < 200) begin
            step();
            n++;
        end
        chk("done_latency", n, nb + vlen);
        chk("busy_at_done", {31'd0, sel_b ? busy_b : busy_a}, 32'd0);
        chk("ready_at_done", {31'd0, rdy(sel_b)}, 32'd0);
        chk("error_at_done", {31'd0, sel_b ? err_b : err_a}, {31'd0, exp_err});
        chk("handshakes", (sel_b ? hs_b : hs_a) - base_hs, nw);
        chk("shift_cycles", (sel_b ? cnt_b : cnt_a) - base_cnt, len + vlen);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; word_valid = 1'b0; word_data = 8'h00;
        step(); step();
        chk("rst_ready", {31'd0, ready_a}, 32'd0);
        chk("rst_head", {31'd0, head_a}, 32'd0);
        chk("rst_shift", {31'd0, sh_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_error", {31'd0, err_a}, 32'd0);
        reset = 1'b0;
        step();

        // Basic 16-bit load
        run_load(1'b0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);
`ifdef CFG_READBACK_EN
        chk("chain_contents", chain_a, 16'h3CA5);
`endif
        // Partial last word on the 12-bit chain
        run_load(1'b1, 8'h00, 8'hFF, 0, 1'b0, 1'b0);
        // Backpressure gap between words
        run_load(1'b0, 8'hA5, 8'h3C, 5, 1'b0, 1'b0);
        // start pulsed during SHIFT is ignored
        run_load(1'b0, 8'hA5, 8'h3C, 0, 1'b1, 1'b0);

        // Reset mid-shift, after the third bit
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        send_word(1'b0, 8'hA5, 8, 0, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrst_ready", {31'd0, ready_a}, 32'd0);
        chk("midrst_head", {31'd0, head_a}, 32'd0);
        chk("midrst_shift", {31'd0, sh_a}, 32'd0);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_done", {31'd0, done_a}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        step();
        run_load(1'b0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);
`ifdef CFG_READBACK_EN
        chk("chain_after_reload", chain_a, 16'h3CA5);
        // Corrupt one chain bit just before VERIFY
        inject = 1'b1;
        run_load(1'b0, 8'hA5, 8'h3C, 0, 1'b0, 1'b1);
        inject = 1'b0;
        chk("done_with_error", {31'd0, done_a}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
